axil_arbiter_rd_wrr: RTL and testbench
======================================

AXIL_ARBITER_RD_WRR -- requirements
Module: axil_arbiter_rd_wrr

Interface
REQ-001 SHALL have parameter NUMBER_MASTER, default 4, number of requesting masters (2..16).
REQ-002 SHALL have parameter WEIGHT_W, default 4, width of each per-master weight field.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, watchdog limit in cycles; used only when the REQ-022 macro is defined.
REQ-004 SHALL have port aclk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port areset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port request_rd  input  NUMBER_MASTER  per-master read request.
REQ-007 SHALL have port weight  input  NUMBER_MASTER*WEIGHT_W  weight of master i at bits [i*WEIGHT_W +: WEIGHT_W].
REQ-008 SHALL have port s_axil_rvalid  input  1  slave read-data valid.
REQ-009 SHALL have port m_axil_rready  input  NUMBER_MASTER  per-master read-data ready.
REQ-010 SHALL have port grant_rd  output  NUMBER_MASTER  one-hot grant, registered.
REQ-011 SHALL have port grant_rd_idx  output  $clog2(NUMBER_MASTER)  binary index of the granted master, registered.
REQ-012 SHALL have port busy  output  1  high while in ACKN.
REQ-013 SHALL have port timeout_err  output  1  one-cycle watchdog-abort pulse.

Function
REQ-014 SHALL implement two states: IDLE and ACKN; busy = (state == ACKN).
REQ-015 In IDLE with request_rd == 0: stay in IDLE; grant_rd = 0.
REQ-016 In IDLE with any request: next cycle enter ACKN and drive the selected grant (1-cycle request-to-grant latency).
REQ-017 Selection: if request_rd[ptr] = 1 and burst count < eff_weight[ptr], regrant ptr and increment count; otherwise select the first requester scanning from ptr+1 upward with wrap-around modulo NUMBER_MASTER, set ptr to it, and set count to 1.
REQ-018 eff_weight[i] = weight[i], or 1 when weight[i] == 0; weight is sampled only at the IDLE decision cycle.
REQ-019 In ACKN: hold grant_rd/grant_rd_idx stable until s_axil_rvalid && m_axil_rready[grant_rd_idx]; on that cycle clear grant_rd to 0 and return to IDLE; there is at least 1 IDLE cycle between grants.
REQ-020 Deassertion of request_rd by the granted master during ACKN does not release the grant; only completion (or timeout) does.
REQ-021 grant_rd SHALL be zero or one-hot at all times; m_axil_rready of non-granted masters is ignored.

Configuration
REQ-022 Macro AXIL_ARBITER_RD_TIMEOUT_EN defined: a counter clears on ACKN entry and increments each ACKN cycle; when it reaches TIMEOUT_CYCLES without completion, return to IDLE, clear grant_rd, pulse timeout_err for 1 cycle, and force count = eff_weight[ptr] so the next selection rotates.
REQ-023 If completion and timeout coincide in the same cycle, completion wins and timeout_err stays 0.
REQ-024 Macro not defined: no watchdog counter exists, ACKN waits indefinitely, and timeout_err is tied to 0.

Reset
REQ-025 areset SHALL asynchronously force state = IDLE, grant_rd = 0, grant_rd_idx = 0, busy = 0, timeout_err = 0, count = 0, ptr = NUMBER_MASTER-1 (so the first rotation picks master 0), and watchdog counter = 0.
REQ-026 Reset asserted mid-ACKN SHALL drop the grant immediately (asynchronously); after release, arbitration restarts per REQ-025.

Verification (NUMBER_MASTER=4, WEIGHT_W=4)
REQ-027 After reset, request_rd=4'b1010 -> grant_rd=4'b0010 one cycle later, grant_rd_idx=1, busy=1.
REQ-028 weight={1,1,3,1} (masters 3..0) with master 1 requesting continuously and rvalid/rready completing each transaction -> master 1 granted 3 consecutive times.
REQ-029 All masters requesting continuously, all weights 1 -> grant order 0,1,2,3,0; one IDLE cycle between grants.
REQ-030 Granted master 2 drops request_rd[2] mid-ACKN while rvalid=1 and m_axil_rready=4'b0011 -> grant is held, with no completion until m_axil_rready[2]=1.
REQ-031 With macro defined and TIMEOUT_CYCLES=8, grant master 0 and never assert rvalid -> after 8 ACKN cycles grant_rd=0 and timeout_err pulses 1 cycle; next grant goes to master 1 if it is requesting.
REQ-032 Assert areset during ACKN -> grant_rd=0 with no clock edge; after release, request_rd=4'b1111 -> master 0 granted.

Source files
------------

// File: rtl/axil_arbiter_rd_wrr_if.sv
// Request/grant bundle between the read-channel masters and the weighted
// round-robin read arbiter. The arbiter sits on the master modport.
interface axil_arbiter_rd_wrr_if #(
  parameter int NUMBER_MASTER = 4,
  parameter int WEIGHT_W      = 4
);
  localparam int IDX_W = $clog2(NUMBER_MASTER);

  logic [NUMBER_MASTER-1:0]          request_rd;
  logic [NUMBER_MASTER*WEIGHT_W-1:0] weight;
  logic                              s_axil_rvalid;
  logic [NUMBER_MASTER-1:0]          m_axil_rready;
  logic [NUMBER_MASTER-1:0]          grant_rd;
  logic [IDX_W-1:0]                  grant_rd_idx;
  logic                              busy;
  logic                              timeout_err;

  modport master (
    input  request_rd, weight, s_axil_rvalid, m_axil_rready,
    output grant_rd, grant_rd_idx, busy, timeout_err
  );

  modport slave (
    output request_rd, weight, s_axil_rvalid, m_axil_rready,
    input  grant_rd, grant_rd_idx, busy, timeout_err
  );
endinterface

// File: rtl/axil_arbiter_rd_wrr.sv
// Weighted round-robin arbiter for the AXI-Lite read channel.
// Optional ACKN watchdog enabled by defining AXIL_ARBITER_RD_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no grant; a request present selects the next master
// ACKN  | one master granted; held until rvalid && its rready (or watchdog)
module axil_arbiter_rd_wrr #(
  parameter int NUMBER_MASTER  = 4,
  parameter int WEIGHT_W       = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  aclk,
  input  logic                  areset,
  axil_arbiter_rd_wrr_if.master bus
);
  localparam int IDX_W = $clog2(NUMBER_MASTER);

  if (NUMBER_MASTER < 2 || NUMBER_MASTER > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("axil_arbiter_rd_wrr: unsupported parameter set");
  end

  typedef enum logic {
    IDLE = 1'b0,
    ACKN = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [NUMBER_MASTER-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [IDX_W-1:0]         ptr_q, ptr_d;
  logic [WEIGHT_W-1:0]      count_q, count_d;
  logic                     timeout_q, timeout_d;

  logic [IDX_W-1:0]         scan_sel;
  logic [IDX_W-1:0]         pick;
  logic                     found;
  logic                     regrant;
  logic                     done;
  logic                     wdog_hit;
  logic [WEIGHT_W-1:0]      eff_w_ptr;

  // A zero weight still earns one grant per rotation.
  function automatic logic [WEIGHT_W-1:0] eff_w(
    input logic [IDX_W-1:0]                  i,
    input logic [NUMBER_MASTER*WEIGHT_W-1:0] w
  );
    logic [WEIGHT_W-1:0] v;
    v = w[i*WEIGHT_W +: WEIGHT_W];
    return (v == '0) ? WEIGHT_W'(1) : v;
  endfunction

  assign eff_w_ptr = eff_w(ptr_q, bus.weight);
  // count == 0 means no burst is open, so the reset pointer always rotates.
  assign regrant   = bus.request_rd[ptr_q] && (count_q != '0) && (count_q < eff_w_ptr);
  assign done      = bus.s_axil_rvalid && bus.m_axil_rready[idx_q];
  assign pick      = regrant ? ptr_q : scan_sel;

  always_comb begin
    scan_sel = ptr_q;
    found    = 1'b0;
    for (int k = 1; k <= NUMBER_MASTER; k++) begin
      if (!found && bus.request_rd[(int'(ptr_q) + k) % NUMBER_MASTER]) begin
        scan_sel = IDX_W'((int'(ptr_q) + k) % NUMBER_MASTER);
        found    = 1'b1;
      end
    end
  end

`ifdef AXIL_ARBITER_RD_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_q, wdog_d;

  assign wdog_hit = (state_q == ACKN) && (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wdog_d = '0;
    if (state_q == ACKN && !wdog_hit) begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  assign wdog_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.request_rd) begin
          state_d       = ACKN;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          idx_d         = pick;
          ptr_d         = pick;
          count_d       = regrant ? count_q + 1'b1 : WEIGHT_W'(1);
        end
      end
      ACKN: begin
        if (done) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (wdog_hit) begin
          // Exhaust the burst so an unresponsive master loses its turn.
          state_d   = IDLE;
          grant_d   = '0;
          timeout_d = 1'b1;
          count_d   = eff_w_ptr;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      idx_q     <= '0;
      ptr_q     <= IDX_W'(NUMBER_MASTER - 1);
      count_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      count_q   <= count_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.grant_rd     = grant_q;
  assign bus.grant_rd_idx = idx_q;
  assign bus.busy         = (state_q == ACKN);
  assign bus.timeout_err  = timeout_q;
endmodule

// File: tb/tb_axil_arbiter_rd_wrr.sv
// Bench for axil_arbiter_rd_wrr: directed scenarios plus randomized traffic
// checked against a weighted round-robin reference model.
module tb_axil_arbiter_rd_wrr;
  localparam int N  = 4;
  localparam int WW = 4;
  localparam int TO = 8;
`ifdef AXIL_ARBITER_RD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  axil_arbiter_rd_wrr_if #(.NUMBER_MASTER(N), .WEIGHT_W(WW)) bus ();

  axil_arbiter_rd_wrr #(
    .NUMBER_MASTER (N),
    .WEIGHT_W      (WW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .aclk  (aclk),
    .areset(areset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // reference model: who holds the bus and where the rotation stands
  int m_busy, m_idx, m_ptr, m_count, m_wdog, m_to;
  int seq[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int eff(input int i);
    int v;
    v = (bus.weight >> (i * WW)) & ((1 << WW) - 1);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_idx = 0; m_ptr = N - 1; m_count = 0; m_wdog = 0; m_to = 0;
  endtask

  // advance the model on the edge using the inputs the DUT sees
  task automatic model_edge();
    logic [N-1:0] req;
    int order[$];
    req  = bus.request_rd;
    m_to = 0;
    if (m_busy == 0) begin
      if (req != '0) begin
        order = {};
        for (int k = 1; k <= N; k++)
          if (req[(m_ptr + k) % N]) order.push_back((m_ptr + k) % N);
        if (req[m_ptr] && m_count > 0 && m_count < eff(m_ptr)) begin
          m_count++;
        end else begin
          m_ptr   = order[0];
          m_count = 1;
        end
        m_idx  = m_ptr;
        m_busy = 1;
        m_wdog = 0;
      end
    end else if (bus.s_axil_rvalid && bus.m_axil_rready[m_idx]) begin
      m_busy = 0;
    end else if (TO_EN) begin
      m_wdog++;
      if (m_wdog == TO) begin
        m_busy  = 0;
        m_to    = 1;
        m_count = eff(m_ptr);
      end
    end
  endtask

  task automatic compare_model();
    check("grant", bus.grant_rd, m_busy ? (32'd1 << m_idx) : 32'd0);
    check("idx", bus.grant_rd_idx, m_idx);
    check("busy", bus.busy, m_busy);
    check("timeout", bus.timeout_err, m_to);
    check("onehot", ($countones(bus.grant_rd) <= 1), 1);
  endtask

  task automatic step();
    @(posedge aclk);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    areset = 1'b1;
    #1;
    check("rst_grant", bus.grant_rd, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_idx", bus.grant_rd_idx, 0);
    check("rst_timeout", bus.timeout_err, 0);
    @(posedge aclk);
    @(negedge aclk);
    areset = 1'b0;
    model_reset();
  endtask

  // record the granted index at each new grant; bounded by a cycle budget
  task automatic collect(input int n, output int cycles);
    logic prev;
    seq.delete();
    prev   = bus.busy;
    cycles = 0;
    while (seq.size() < n && cycles < 200) begin
      step();
      cycles++;
      if (bus.busy && !prev) seq.push_back(int'(bus.grant_rd_idx));
      prev = bus.busy;
    end
  endtask

  initial begin
    int cyc;
    int exp28[8] = '{1, 1, 1, 2, 1, 1, 1, 2};
    int exp29[5] = '{0, 1, 2, 3, 0};

    areset            = 1'b1;
    bus.request_rd    = '0;
    bus.weight        = '0;
    bus.s_axil_rvalid = 1'b0;
    bus.m_axil_rready = '0;
    model_reset();
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    areset = 1'b0;
    check("init_grant", bus.grant_rd, 0);
    check("init_busy", bus.busy, 0);

    // first request picks the lowest requester after the reset pointer
    bus.weight     = 16'h1111;
    bus.request_rd = 4'b1010;
    step();
    check("r27_grant", bus.grant_rd, 4'b0010);
    check("r27_idx", bus.grant_rd_idx, 1);
    check("r27_busy", bus.busy, 1);
    bus.s_axil_rvalid = 1'b1;
    bus.m_axil_rready = 4'b0010;
    bus.request_rd    = 4'b0000;
    step();
    check("r27_release", bus.grant_rd, 0);

    // weight 3 on master 1 earns three grants before master 2
    do_reset();
    bus.weight        = 16'h1131;
    bus.request_rd    = 4'b0110;
    bus.s_axil_rvalid = 1'b1;
    bus.m_axil_rready = 4'b1111;
    collect(8, cyc);
    check("r28_count", seq.size(), 8);
    for (int i = 0; i < seq.size() && i < 8; i++) check($sformatf("r28_seq%0d", i), seq[i], exp28[i]);

    // equal weights rotate with one idle cycle between grants
    do_reset();
    bus.weight     = 16'h1111;
    bus.request_rd = 4'b1111;
    collect(5, cyc);
    check("r29_count", seq.size(), 5);
    check("r29_cycles", cyc, 9);
    for (int i = 0; i < seq.size() && i < 5; i++) check($sformatf("r29_seq%0d", i), seq[i], exp29[i]);

    // grant survives request drop and other masters' rready
    do_reset();
    bus.s_axil_rvalid = 1'b0;
    bus.request_rd    = 4'b0100;
    step();
    check("r30_grant", bus.grant_rd, 4'b0100);
    bus.request_rd    = 4'b0000;
    bus.s_axil_rvalid = 1'b1;
    bus.m_axil_rready = 4'b0011;
    repeat (3) begin
      step();
      check("r30_hold", bus.grant_rd, 4'b0100);
    end
    bus.m_axil_rready = 4'b0100;
    step();
    check("r30_done", bus.grant_rd, 0);

    // async reset mid-ACKN, then restart from master 0
    bus.m_axil_rready = 4'b0000;
    bus.request_rd    = 4'b1000;
    step();
    check("r32_pre", bus.grant_rd, 4'b1000);
    do_reset();
    bus.request_rd = 4'b1111;
    step();
    check("r32_grant", bus.grant_rd, 4'b0001);

`ifdef AXIL_ARBITER_RD_TIMEOUT_EN
    do_reset();
    bus.weight        = 16'h1111;
    bus.s_axil_rvalid = 1'b0;
    bus.request_rd    = 4'b0011;
    step();
    check("r31_grant", bus.grant_rd, 4'b0001);
    repeat (7) begin
      step();
      check("r31_hold", bus.grant_rd, 4'b0001);
    end
    step();
    check("r31_drop", bus.grant_rd, 0);
    check("r31_pulse", bus.timeout_err, 1);
    step();
    check("r31_next", bus.grant_rd, 4'b0010);
    check("r31_pulse_end", bus.timeout_err, 0);
`endif

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) != 0) bus.request_rd = N'($urandom_range(0, 15));
      if ($urandom_range(0, 40) == 0) bus.weight = (N*WW)'($urandom);
      bus.s_axil_rvalid = TO_EN ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) == 0);
      bus.m_axil_rready = N'($urandom_range(0, 15));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
